// File: rtl/led_sched_pkg.sv
// Shared encodings and seed constants for the LED scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    SHOOT  = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    OFF    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ANIM     = 2'd0,
    NOTIFY   = 2'd1,
    OVERRIDE = 2'd2
  } arb_state_t;

  localparam logic [7:0] SEED_SHOOT  = 8'h05;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;
  localparam logic [7:0] SEED_FILL   = 8'h00;
  localparam logic [7:0] SEED_OFF    = 8'h00;

  function automatic mode_t next_mode(mode_t m);
    case (m)
      SHOOT:   return BOUNCE;
      BOUNCE:  return FILL;
      FILL:    return OFF;
      default: return SHOOT;
    endcase
  endfunction

  function automatic logic [7:0] mode_seed(mode_t m);
    case (m)
      SHOOT:   return SEED_SHOOT;
      BOUNCE:  return SEED_BOUNCE;
      FILL:    return SEED_FILL;
      default: return SEED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_scheduler_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, and a press pulse on the debounced rise.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 64000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          raw_pressed;

  assign raw_pressed = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Counter only runs while the synced level disagrees with the debounced one.
      if (raw_pressed == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt     <= '0;
        pressed <= raw_pressed;
        press   <= raw_pressed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Shares the 8 LEDs between button override, one-shot notifications and a background animation.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 160000,
  parameter int unsigned DEBOUNCE_CYC = 64000,
  parameter int unsigned NOTIFY_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_n,
  input  logic       notify_req,
  input  logic [7:0] notify_pattern,
  output logic       notify_ack,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed
);
  localparam int unsigned PW = $clog2(STEP_DIV * 8);
  localparam int unsigned NW = $clog2(NOTIFY_STEPS + 1);

  logic [4:0] pressed;
  logic [4:0] press;
  logic       unused_press;

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[i]),
      .pressed(pressed[i]),
      .press  (press[i])
    );
  end

  assign unused_press = press[0] ^ press[4];

  logic [PW-1:0] presc;
  logic [1:0]    speed_q;
  mode_t         mode_q;
  mode_t         mode_nxt;
  logic [7:0]    pat;
  logic          dir_right;
  logic [7:0]    pat_step;
  logic          dir_step;
  logic          tick;
  logic          speed_up;
  logic          speed_dn;
  logic          mode_chg;

  assign mode  = mode_q;
  assign speed = speed_q;

  always_comb begin
    tick     = (presc == PW'((STEP_DIV << speed_q) - 1));
    speed_up = press[3] & ~press[2] & (speed_q != 2'd3);
    speed_dn = press[2] & ~press[3] & (speed_q != 2'd0);
    mode_chg = press[1];
    mode_nxt = next_mode(mode_q);
    pat_step = pat;
    dir_step = dir_right;
    case (mode_q)
      SHOOT:  pat_step = {pat[6:0], pat[7]};
      BOUNCE: begin
        if (!dir_right) begin
          pat_step = pat << 1;
          dir_step = pat[6];
        end else begin
          pat_step = pat >> 1;
          dir_step = ~pat[1];
        end
      end
      FILL:    pat_step = (pat == 8'hFF) ? 8'h00 : {pat[6:0], 1'b1};
      default: pat_step = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      speed_q   <= 2'd0;
      mode_q    <= SHOOT;
      pat       <= SEED_SHOOT;
      dir_right <= 1'b0;
    end else begin
      presc <= (tick || mode_chg || speed_up || speed_dn) ? '0 : presc + 1'b1;
      if (speed_up) begin
        speed_q <= speed_q + 2'd1;
      end else if (speed_dn) begin
        speed_q <= speed_q - 2'd1;
      end
      if (mode_chg) begin
        mode_q    <= mode_nxt;
        pat       <= mode_seed(mode_nxt);
        dir_right <= 1'b0;
      end else if (tick) begin
        pat       <= pat_step;
        dir_right <= dir_step;
      end
    end
  end

  arb_state_t    state;
  arb_state_t    state_next;
  logic          susp;
  logic          susp_next;
  logic [NW-1:0] ncnt;
  logic [NW-1:0] ncnt_next;
  logic [7:0]    npat;
  logic [7:0]    npat_next;
  logic [7:0]    led_next;

  always_comb begin
    state_next = state;
    susp_next  = susp;
    ncnt_next  = ncnt;
    npat_next  = npat;
    notify_ack = 1'b0;
    // A notification with steps left is parked under the override and resumed afterwards.
    if (pressed[0]) begin
      state_next = OVERRIDE;
      if (state == NOTIFY && ncnt != '0) begin
        susp_next = 1'b1;
      end
    end else begin
      case (state)
        OVERRIDE: begin
          state_next = susp ? NOTIFY : ANIM;
          susp_next  = 1'b0;
        end
        NOTIFY: begin
          if (ncnt == '0) begin
            state_next = ANIM;
          end else if (tick) begin
            ncnt_next = ncnt - 1'b1;
          end
        end
        default: begin
          if (notify_req && !rst) begin
            notify_ack = 1'b1;
            npat_next  = notify_pattern;
            ncnt_next  = NW'(NOTIFY_STEPS);
            state_next = NOTIFY;
          end
        end
      endcase
    end
    case (state_next)
      OVERRIDE: led_next = {3'b000, pressed};
      NOTIFY:   led_next = npat_next;
      default:  led_next = pat;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ANIM;
      susp  <= 1'b0;
      ncnt  <= '0;
      npat  <= '0;
      led   <= '0;
    end else begin
      state <= state_next;
      susp  <= susp_next;
      ncnt  <= ncnt_next;
      npat  <= npat_next;
      led   <= led_next;
    end
  end

endmodule
